// File: rtl/fb_pkg.sv
// Frame-buffer constants and pixel-format helpers shared by the scan-out reader
// and the Ethernet writer.
package fb_pkg;

  localparam int FB_WIDTH_DEF    = 256;
  localparam int FB_HEIGHT_DEF   = 192;
  localparam int SCALE_SHIFT_DEF = 2;

  // RGB332 field positions within a frame-buffer byte
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  // Sideband bits that ride alongside the BRAM read
  typedef struct packed {
    logic in_win;
    logic blank;
    logic hsync;
    logic vsync;
  } align_t;

  // Widen by replicating MSBs so full-scale input maps to full-scale output.
  function automatic logic [11:0] rgb332_to_rgb12(input logic [7:0] px);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = px[R_MSB:R_LSB];
    g = px[G_MSB:G_LSB];
    b = px[B_MSB:B_LSB];
    return {r, r[2], g, g[2], b, b};
  endfunction

endpackage

// File: rtl/fb_pixel_reader_delay_line.sv
// Fixed-depth shift register with asynchronous reset to a chosen value; keeps
// sideband bits aligned with the frame-buffer read latency.
module delay_line #(
  parameter int              WIDTH     = 1,
  parameter int              DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/fb_pixel_reader.sv
// Scan-out side of a double-buffered RGB332 frame buffer: scales the buffer up
// onto the VGA raster and swaps front/back only at the start of vblank.
module fb_pixel_reader
  import fb_pkg::*;
#(
  parameter int         FB_WIDTH     = FB_WIDTH_DEF,
  parameter int         FB_HEIGHT    = FB_HEIGHT_DEF,
  parameter int         SCALE_SHIFT  = SCALE_SHIFT_DEF,
  parameter int         V_ACTIVE     = 768,
  parameter int         READ_LATENCY = 2,
  parameter logic [11:0] BORDER_RGB  = 12'h000,
  localparam int        COL_W        = $clog2(FB_WIDTH),
  localparam int        ROW_W        = $clog2(FB_HEIGHT),
  localparam int        ADDR_W       = 1 + ROW_W + COL_W
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  input  logic              swap_req_in,
  output logic              swap_ack_out,
  output logic              write_buf_out,
  output logic [ADDR_W-1:0] fb_addr_out,
  input  logic [7:0]        fb_data_in,
  output logic [11:0]       rgb_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out
);

  localparam logic [31:0] WIN_W = 32'(FB_WIDTH) << SCALE_SHIFT;
  localparam logic [31:0] WIN_H = 32'(FB_HEIGHT) << SCALE_SHIFT;
  localparam align_t ALIGN_RESET = '{in_win: 1'b0, blank: 1'b1, hsync: 1'b1, vsync: 1'b1};

  logic [10:0]      hcount_s0;
  logic [9:0]       vcount_s0;
  logic             hsync_s0;
  logic             vsync_s0;
  logic             blank_s0;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             in_win;
  align_t           align_s1;
  align_t           align_out;
  logic             read_buf;
  logic             pending;
  logic             apply;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcount_s0 <= '0;
      vcount_s0 <= '0;
      hsync_s0  <= 1'b1;
      vsync_s0  <= 1'b1;
      blank_s0  <= 1'b1;
    end else begin
      hcount_s0 <= hcount_in;
      vcount_s0 <= vcount_in;
      hsync_s0  <= hsync_in;
      vsync_s0  <= vsync_in;
      blank_s0  <= blank_in;
    end
  end

  // Window test uses the full-width counts; only then are indices truncated.
  assign in_win = ({21'd0, hcount_s0} < WIN_W) && ({22'd0, vcount_s0} < WIN_H);
  assign col    = COL_W'(hcount_s0 >> SCALE_SHIFT);
  assign row    = ROW_W'(vcount_s0 >> SCALE_SHIFT);

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      fb_addr_out <= '0;
      align_s1    <= ALIGN_RESET;
    end else begin
      fb_addr_out <= {read_buf, row, col};
      align_s1    <= '{in_win: in_win, blank: blank_s0, hsync: hsync_s0, vsync: vsync_s0};
    end
  end

  delay_line #(
    .WIDTH    ($bits(align_t)),
    .DEPTH    (READ_LATENCY),
    .RESET_VAL(ALIGN_RESET)
  ) u_align (
    .clk(pixel_clk_in),
    .rst(rst_in),
    .d  (align_s1),
    .q  (align_out)
  );

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      rgb_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      hsync_out <= align_out.hsync;
      vsync_out <= align_out.vsync;
      blank_out <= align_out.blank;
      if (align_out.blank) begin
        rgb_out <= '0;
      end else if (!align_out.in_win) begin
        rgb_out <= BORDER_RGB;
      end else begin
        rgb_out <= rgb332_to_rgb12(fb_data_in);
      end
    end
  end

  // The apply point is the first pixel of vblank as seen by S0.
  assign apply = (hcount_s0 == '0) && (vcount_s0 == 10'(V_ACTIVE));

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      read_buf     <= 1'b0;
      pending      <= 1'b0;
      swap_ack_out <= 1'b0;
    end else begin
      swap_ack_out <= 1'b0;
      if (apply && (pending || swap_req_in)) begin
        read_buf     <= ~read_buf;
        pending      <= 1'b0;
        swap_ack_out <= 1'b1;
      end else if (swap_req_in) begin
        pending <= 1'b1;
      end
    end
  end

  assign write_buf_out = ~read_buf;

endmodule

// File: tb/tb_fb_pixel_reader.sv
// Bench for fb_pixel_reader: default-size and 128x96 instances share one raster,
// each fed by a BRAM model whose contents are a function of buffer/row/col.
module tb_fb_pixel_reader;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank, swap_req;
  logic        force_ff;

  logic        ack_a, wbuf_a, hs_a, vs_a, bl_a;
  logic [16:0] addr_a;
  logic [7:0]  data_a;
  logic [11:0] rgb_a;
  logic        ack_b, wbuf_b, hs_b, vs_b, bl_b;
  logic [14:0] addr_b;
  logic [7:0]  data_b;
  logic [11:0] rgb_b;

  always #5 clk = ~clk;

  fb_pixel_reader dut_a (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank), .swap_req_in(swap_req),
    .swap_ack_out(ack_a), .write_buf_out(wbuf_a), .fb_addr_out(addr_a),
    .fb_data_in(data_a), .rgb_out(rgb_a), .hsync_out(hs_a), .vsync_out(vs_a),
    .blank_out(bl_a)
  );

  fb_pixel_reader #(.FB_WIDTH(128), .FB_HEIGHT(96), .BORDER_RGB(12'h5A3)) dut_b (
    .pixel_clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank), .swap_req_in(swap_req),
    .swap_ack_out(ack_b), .write_buf_out(wbuf_b), .fb_addr_out(addr_b),
    .fb_data_in(data_b), .rgb_out(rgb_b), .hsync_out(hs_b), .vsync_out(vs_b),
    .blank_out(bl_b)
  );

  // Buffer 0 holds (row+col), buffer 1 the same XOR A5 so swaps are visible.
  function automatic logic [7:0] fb_val(input bit b, input int row, input int col);
    logic [7:0] s;
    s = 8'((row + col) & 255);
    return b ? (s ^ 8'hA5) : s;
  endfunction

  logic [7:0] pipe_a [LAT];
  logic [7:0] pipe_b [LAT];
  always @(posedge clk) begin
    pipe_a[0] <= fb_val(addr_a[16], int'(addr_a[15:8]), int'(addr_a[7:0]));
    pipe_b[0] <= fb_val(addr_b[14], int'(addr_b[13:7]), int'(addr_b[6:0]));
    for (int i = 1; i < LAT; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign data_a = force_ff ? 8'hFF : pipe_a[LAT-1];
  assign data_b = force_ff ? 8'hFF : pipe_b[LAT-1];

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit bl;
  } rec_t;

  rec_t hist[$];
  bit   bufh[$];
  bit   bufm, pend;
  int   n_cmp, n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_addr(input rec_t r, input bit b, input int cw, input int rw);
    int col, row;
    col = (r.h / 4) % (1 << cw);
    row = (r.v / 4) % (1 << rw);
    return (32'(b) << (rw + cw)) | (32'(row) << cw) | 32'(col);
  endfunction

  function automatic logic [11:0] exp_rgb(input rec_t r, input bit b, input int fw, input int fh,
                                          input logic [11:0] border);
    int p, rr, gg, bb;
    if (r.bl) return 12'h000;
    if (r.h >= fw * 4 || r.v >= fh * 4) return border;
    p  = int'(fb_val(b, r.v / 4, r.h / 4));
    rr = p / 32;
    gg = (p / 4) % 8;
    bb = p % 4;
    return 12'((2 * rr + rr / 4) * 256 + (2 * gg + gg / 4) * 16 + bb * 5);
  endfunction

  task automatic model_reset();
    rec_t idle;
    idle = '{0, 0, 1'b1, 1'b1, 1'b1};
    hist.delete();
    bufh.delete();
    for (int i = 0; i < 5; i++) begin
      hist.push_front(idle);
      bufh.push_front(1'b0);
    end
    bufm = 1'b0;
    pend = 1'b0;
  endtask

  // One clock: log the sampled inputs, advance the swap model, compare everything.
  task automatic step();
    rec_t cur, r1, r4;
    bit   req, apply, ack_e;
    @(posedge clk);
    cur = '{int'(hcount), int'(vcount), hsync, vsync, blank};
    req = swap_req;
    hist.push_front(cur);
    void'(hist.pop_back());
    apply = (hist[1].h == 0) && (hist[1].v == 768);
    ack_e = 1'b0;
    if (apply && (pend || req)) begin
      bufm  = !bufm;
      pend  = 1'b0;
      ack_e = 1'b1;
    end else if (req) begin
      pend = 1'b1;
    end
    bufh.push_front(bufm);
    void'(bufh.pop_back());
    #1;
    r1 = hist[1];
    r4 = hist[4];
    chk("addr_a", 32'(addr_a), exp_addr(r1, bufh[1], 8, 8));
    chk("addr_b", 32'(addr_b), exp_addr(r1, bufh[1], 7, 7));
    chk("rgb_a", 32'(rgb_a), 32'(exp_rgb(r4, bufh[4], 256, 192, 12'h000)));
    chk("rgb_b", 32'(rgb_b), 32'(exp_rgb(r4, bufh[4], 128, 96, 12'h5A3)));
    chk("hsync_a", 32'(hs_a), 32'(r4.hs));
    chk("vsync_a", 32'(vs_a), 32'(r4.vs));
    chk("blank_a", 32'(bl_a), 32'(r4.bl));
    chk("hsync_b", 32'(hs_b), 32'(r4.hs));
    chk("vsync_b", 32'(vs_b), 32'(r4.vs));
    chk("blank_b", 32'(bl_b), 32'(r4.bl));
    chk("wbuf_a", 32'(wbuf_a), 32'(!bufm));
    chk("wbuf_b", 32'(wbuf_b), 32'(!bufm));
    chk("ack_a", 32'(ack_a), 32'(ack_e));
    chk("ack_b", 32'(ack_b), 32'(ack_e));
  endtask

  task automatic rawpix(input int h, input int v, input bit hs, input bit vs, input bit bl,
                        input bit req);
    hcount   = 11'(h);
    vcount   = 10'(v);
    hsync    = hs;
    vsync    = vs;
    blank    = bl;
    swap_req = req;
    step();
  endtask

  task automatic pix(input int h, input int v, input bit req);
    rawpix(h, v, !(h >= 1048 && h < 1184), !(v >= 771 && v < 777), (h >= 1024 || v >= 768), req);
  endtask

  task automatic walk(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) pix(h, v, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rgb_a"}, 32'(rgb_a), 32'h0);
    chk({tag, "_rgb_b"}, 32'(rgb_b), 32'h0);
    chk({tag, "_syncs_a"}, 32'({hs_a, vs_a, bl_a}), 32'h7);
    chk({tag, "_syncs_b"}, 32'({hs_b, vs_b, bl_b}), 32'h7);
    chk({tag, "_addr_a"}, 32'(addr_a), 32'h0);
    chk({tag, "_addr_b"}, 32'(addr_b), 32'h0);
    chk({tag, "_ack"}, 32'({ack_a, ack_b}), 32'h0);
    chk({tag, "_wbuf"}, 32'({wbuf_a, wbuf_b}), 32'h3);
  endtask

  typedef struct {
    int          h;
    int          v;
    logic [16:0] addr_a;
    logic [11:0] rgb_a;
    logic [11:0] rgb_b;
  } vec_t;

  vec_t tbl[9];

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    force_ff = 1'b0;
    rst      = 1'b1;
    hcount   = '0;
    vcount   = '0;
    hsync    = 1'b1;
    vsync    = 1'b1;
    blank    = 1'b1;
    swap_req = 1'b0;

    tbl[0] = '{8,    4,   17'h00102, 12'h00F, 12'h00F};
    tbl[1] = '{600,  100, 17'h01996, 12'hB6F, 12'h5A3};
    tbl[2] = '{1100, 100, 17'h01913, 12'h000, 12'h000};
    tbl[3] = '{1023, 767, 17'h0BFFF, 12'hBFA, 12'h5A3};
    tbl[4] = '{511,  383, 17'h05F7F, 12'hDFA, 12'hDFA};
    tbl[5] = '{512,  383, 17'h05F80, 12'hDFF, 12'h5A3};
    tbl[6] = '{0,    0,   17'h00000, 12'h000, 12'h000};
    tbl[7] = '{4,    384, 17'h06001, 12'h605, 12'h5A3};
    tbl[8] = '{900,  800, 17'h0C8E1, 12'h000, 12'h000};

    #1;
    chk_reset("por");
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b0;
    model_reset();

    // Directed pixels, read buffer 0: address one cycle after capture, colour four.
    foreach (tbl[i]) begin
      pix(tbl[i].h, tbl[i].v, 1'b0);
      pix(tbl[i].h, tbl[i].v, 1'b0);
      chk("tbl_addr", 32'(addr_a), 32'(tbl[i].addr_a));
      pix(tbl[i].h, tbl[i].v, 1'b0);
      pix(tbl[i].h, tbl[i].v, 1'b0);
      pix(tbl[i].h, tbl[i].v, 1'b0);
      chk("tbl_rgb_a", 32'(rgb_a), 32'(tbl[i].rgb_a));
      chk("tbl_rgb_b", 32'(rgb_b), 32'(tbl[i].rgb_b));
    end

    // Single request mid-frame, then raster through vblank.
    for (int h = 0; h <= 20; h++) pix(h, 300, h == 10);
    chk("swap_hold_wbuf", 32'(wbuf_a), 32'h1);
    walk(766, 0, 1343);
    walk(767, 0, 1343);
    chk("swap_pre_apply_wbuf", 32'(wbuf_a), 32'h1);
    pix(0, 768, 1'b0);
    chk("swap_pre_ack", 32'(ack_a), 32'h0);
    pix(1, 768, 1'b0);
    chk("swap_ack", 32'(ack_a), 32'h1);
    chk("swap_wbuf", 32'(wbuf_a), 32'h0);
    pix(2, 768, 1'b0);
    chk("swap_ack_1cyc", 32'(ack_a), 32'h0);
    walk(768, 3, 1343);
    for (int v = 769; v <= 778; v++) walk(v, 0, 1343);
    pix(8, 4, 1'b0);
    pix(9, 4, 1'b0);
    chk("swap_addr_msb", 32'(addr_a[16]), 32'h1);
    chk("swap_addr", 32'(addr_a), 32'h10102);

    // Three requests in one frame collapse to a single swap.
    for (int k = 1; k <= 3; k++) begin
      pix(5, 100 * k, 1'b1);
      pix(6, 100 * k, 1'b0);
    end
    pix(0, 768, 1'b0);
    pix(1, 768, 1'b0);
    chk("multi_ack", 32'(ack_a), 32'h1);
    chk("multi_wbuf", 32'(wbuf_a), 32'h1);
    pix(2, 768, 1'b0);
    pix(100, 768, 1'b0);
    pix(0, 768, 1'b0);
    pix(1, 768, 1'b0);
    chk("multi_no_second_ack", 32'(ack_a), 32'h0);
    chk("multi_no_second_wbuf", 32'(wbuf_a), 32'h1);

    // Request in the apply cycle itself is consumed there.
    pix(0, 768, 1'b0);
    pix(1, 768, 1'b1);
    chk("coinc_ack", 32'(ack_a), 32'h1);
    chk("coinc_wbuf", 32'(wbuf_a), 32'h0);
    pix(2, 768, 1'b0);
    chk("coinc_ack_1cyc", 32'(ack_a), 32'h0);

    // Request one cycle late waits for the next apply point.
    pix(0, 768, 1'b0);
    pix(1, 768, 1'b0);
    chk("late_no_ack", 32'(ack_a), 32'h0);
    pix(2, 768, 1'b1);
    chk("late_no_toggle", 32'(wbuf_a), 32'h0);
    pix(3, 768, 1'b0);
    pix(0, 768, 1'b0);
    pix(1, 768, 1'b0);
    chk("late_next_ack", 32'(ack_a), 32'h1);
    chk("late_next_wbuf", 32'(wbuf_a), 32'h1);

    // Held request away from the apply point never toggles.
    for (int i = 0; i < 50; i++) pix(400 + i, 400, 1'b1);
    chk("held_req_wbuf", 32'(wbuf_a), 32'h1);
    pix(450, 400, 1'b0);
    pix(0, 768, 1'b0);
    pix(1, 768, 1'b0);
    chk("held_apply_ack", 32'(ack_a), 32'h1);
    chk("held_apply_wbuf", 32'(wbuf_a), 32'h0);

    // Blanked pixels stay black even with all-ones read data.
    for (int h = 1100; h <= 1139; h++) begin
      force_ff = (h >= 1106 && h <= 1125);
      pix(h, 100, 1'b0);
      if (h >= 1110 && h <= 1129) begin
        chk("blank_ff_a", 32'(rgb_a), 32'h0);
        chk("blank_ff_b", 32'(rgb_b), 32'h0);
      end
    end
    force_ff = 1'b0;

    // Random raster positions, sync levels and swap requests.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0)
        rawpix(0, 768, 1'($urandom), 1'($urandom), 1'b1, $urandom_range(0, 15) == 0);
      else
        rawpix(int'($urandom_range(0, 1343)), int'($urandom_range(0, 805)),
               1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset mid-line.
    for (int h = 480; h <= 500; h++) pix(h, 100, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async");
    @(posedge clk);
    @(posedge clk);
    #4;
    rst = 1'b0;
    model_reset();
    pix(501, 100, 1'b0);
    chk("post_rst_wbuf", 32'(wbuf_a), 32'h1);
    for (int h = 502; h <= 540; h++) pix(h, 100, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
